// File: rtl/row_fetch.sv
// Row fetcher: reads a top/bottom panel row pair from frame-buffer RAM, one word per cycle,
// and commits both assembled rows to double-buffered outputs in the same edge.
//
// state  | meaning
// IDLE   | no fetch in flight, waiting for read_en
// READ   | issuing the 2*WORDS RAM reads for the current request
// COMMIT | last read data in flight; rows commit once it has been captured
module row_fetch #(
    parameter int  WORD_W  = 16,
    parameter int  ROW_W   = 64,
    localparam int WORDS   = ROW_W / WORD_W,
    localparam int WORD_AW = $clog2(WORDS),
    localparam int BEAT_W  = WORD_AW + 1,
    localparam int ADDR_W  = 7 + WORD_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read_en,
    input  logic [4:0]        addr,
    input  logic              frame_sel,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [ROW_W-1:0]  row_0_out,
    output logic [ROW_W-1:0]  row_1_out,
    output logic              rows_valid,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        COMMIT
    } state_t;

    state_t              state_q, state_d;
    logic [4:0]          req_addr_q;
    logic                req_frame_q;
    logic [BEAT_W-1:0]   beat_q;
    logic                pend_valid_q;
    logic [4:0]          pend_addr_q;
    logic                pend_frame_q;
    logic                rd_valid_q;
    logic [BEAT_W-1:0]   rd_beat_q;
    logic [ROW_W-1:0]    shadow_0_q, shadow_1_q;

    logic                start;
    logic                commit;
    logic [4:0]          start_addr;
    logic                start_frame;

    always_comb begin
        state_d     = state_q;
        start       = 1'b0;
        commit      = 1'b0;
        start_addr  = addr;
        start_frame = frame_sel;
        case (state_q)
            IDLE: begin
                if (read_en) start = 1'b1;
            end
            READ: begin
                if (beat_q == BEAT_W'(2 * WORDS - 1)) state_d = COMMIT;
            end
            COMMIT: begin
                // rd_valid_q low means the final word was captured on the previous edge
                if (!rd_valid_q) begin
                    commit = 1'b1;
                    if (read_en) begin
                        start = 1'b1;
                    end else if (pend_valid_q) begin
                        start       = 1'b1;
                        start_addr  = pend_addr_q;
                        start_frame = pend_frame_q;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (start) state_d = READ;
    end

    assign mem_ren   = (state_q == READ);
    assign busy      = (state_q != IDLE);
    assign mem_raddr = mem_ren ? {req_frame_q, beat_q[WORD_AW], req_addr_q, beat_q[WORD_AW-1:0]}
                               : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            req_addr_q   <= '0;
            req_frame_q  <= 1'b0;
            beat_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_frame_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_beat_q    <= '0;
        end else begin
            state_q    <= state_d;
            rd_valid_q <= mem_ren;
            rd_beat_q  <= beat_q;
            if (start) begin
                req_addr_q  <= start_addr;
                req_frame_q <= start_frame;
                beat_q      <= '0;
            end else if (mem_ren) begin
                beat_q <= beat_q + 1'b1;
            end
            // a start while busy only happens at commit; it supersedes any pending request
            if (start && busy) begin
                pend_valid_q <= 1'b0;
            end else if (busy && read_en) begin
                pend_valid_q <= 1'b1;
                pend_addr_q  <= addr;
                pend_frame_q <= frame_sel;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_0_q <= '0;
            shadow_1_q <= '0;
            row_0_out  <= '0;
            row_1_out  <= '0;
            rows_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= commit;
            if (rd_valid_q) begin
                for (int w = 0; w < WORDS; w++) begin
                    if (rd_beat_q[WORD_AW-1:0] == WORD_AW'(w)) begin
                        if (rd_beat_q[WORD_AW]) shadow_1_q[w*WORD_W +: WORD_W] <= mem_rdata;
                        else                    shadow_0_q[w*WORD_W +: WORD_W] <= mem_rdata;
                    end
                end
            end
            if (commit) begin
                row_0_out  <= shadow_0_q;
                row_1_out  <= shadow_1_q;
                rows_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_row_fetch.sv
// Scoreboard bench for row_fetch: a request-level model predicts RAM addresses and committed
// row pairs; a negedge monitor pops and compares whenever the DUT reads or commits.
module tb_row_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        read_en;
    logic [4:0]  addr;
    logic        frame_sel;
    logic        mem_ren;
    logic [8:0]  mem_raddr;
    logic [15:0] mem_rdata;
    logic [63:0] row_0_out, row_1_out;
    logic        rows_valid, busy, done;

    row_fetch dut (
        .clk        (clk),
        .reset      (reset),
        .read_en    (read_en),
        .addr       (addr),
        .frame_sel  (frame_sel),
        .mem_ren    (mem_ren),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .row_0_out  (row_0_out),
        .row_1_out  (row_1_out),
        .rows_valid (rows_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [512];
    always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_raddr];

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard queues and last committed pair
    logic [8:0]   addr_q [$];
    logic [127:0] row_q  [$];
    logic [63:0]  cur0 = '0, cur1 = '0;
    logic         cur_valid = 1'b0;
    logic [8:0]   exp_addr;
    logic [63:0]  e0, e1;

    // request-level model
    bit          active = 0, pend_v = 0, just_committed = 0;
    int          edge_n = 0, end_edge = 0;
    logic [4:0]  pend_a;
    logic        pend_f;

    function automatic logic [63:0] exp_row(input int f, input int h, input int a);
        logic [63:0] r;
        for (int w = 0; w < 4; w++) r[w*16 +: 16] = mem[f*256 + h*128 + a*4 + w];
        return r;
    endfunction

    task automatic start_fetch(input logic [4:0] a, input logic f);
        for (int h = 0; h < 2; h++)
            for (int w = 0; w < 4; w++)
                addr_q.push_back(9'(int'(f)*256 + h*128 + int'(a)*4 + w));
        row_q.push_back({exp_row(int'(f), 1, int'(a)), exp_row(int'(f), 0, int'(a))});
        active   = 1;
        end_edge = edge_n + 10;
    endtask

    task automatic step(input logic re, input logic [4:0] a, input logic f);
        @(negedge clk);
        chk("busy", 64'(busy), 64'(active));
        chk("done timing", 64'(done), 64'(just_committed));
        chk("mem_ren timing", 64'(mem_ren), 64'(active && (end_edge - edge_n >= 3)));
        read_en = re; addr = a; frame_sel = f;
        @(posedge clk);
        edge_n++;
        just_committed = 0;
        if (active && edge_n == end_edge) begin
            just_committed = 1;
            if (re) begin
                pend_v = 0;
                start_fetch(a, f);
            end else if (pend_v) begin
                pend_v = 0;
                start_fetch(pend_a, pend_f);
            end else begin
                active = 0;
            end
        end else if (active) begin
            if (re) begin
                pend_v = 1; pend_a = a; pend_f = f;
            end
        end else if (re) begin
            start_fetch(a, f);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_ren) begin
                if (addr_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected mem_ren: got raddr %h expected no read", mem_raddr);
                end else begin
                    exp_addr = addr_q.pop_front();
                    chk("mem_raddr", 64'(mem_raddr), 64'(exp_addr));
                end
            end
            if (done) begin
                if (row_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected done: got done=1 expected no commit");
                end else begin
                    {e1, e0} = row_q.pop_front();
                    chk("row_0_out commit", row_0_out, e0);
                    chk("row_1_out commit", row_1_out, e1);
                    chk("rows_valid commit", 64'(rows_valid), 64'd1);
                    cur0 = e0; cur1 = e1; cur_valid = 1'b1;
                end
            end else begin
                chk("row_0_out stable", row_0_out, cur0);
                chk("row_1_out stable", row_1_out, cur1);
                chk("rows_valid", 64'(rows_valid), 64'(cur_valid));
            end
        end
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
        reset = 1'b1; read_en = 1'b0; addr = '0; frame_sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset mem_ren", 64'(mem_ren), 64'd0);
        chk("reset mem_raddr", 64'(mem_raddr), 64'd0);
        chk("reset row_0_out", row_0_out, 64'd0);
        chk("reset row_1_out", row_1_out, 64'd0);
        chk("reset rows_valid", 64'(rows_valid), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // single fetch, then boundary row 31 of frame 1
        step(1'b1, 5'd5, 1'b0);
        idle(12);
        step(1'b1, 5'd31, 1'b1);
        idle(12);

        // back-to-back: addr 2 at E0, addr 9 at E3
        step(1'b1, 5'd2, 1'b0);
        idle(2);
        step(1'b1, 5'd9, 1'b0);
        idle(20);

        // latest wins: addr 4 at E2 overwritten by addr 6 at E5
        step(1'b1, 5'd11, 1'b1);
        idle(1);
        step(1'b1, 5'd4, 1'b0);
        idle(2);
        step(1'b1, 5'd6, 1'b0);
        idle(20);

        // request landing exactly on the commit edge, with an older pending one
        step(1'b1, 5'd1, 1'b0);
        step(1'b1, 5'd3, 1'b1);
        idle(8);
        step(1'b1, 5'd30, 1'b0);
        idle(12);

        // reset mid-fetch, with a request held while reset is asserted
        step(1'b1, 5'd17, 1'b1);
        idle(4);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort mem_ren", 64'(mem_ren), 64'd0);
        chk("abort row_0_out", row_0_out, 64'd0);
        chk("abort row_1_out", row_1_out, 64'd0);
        chk("abort rows_valid", 64'(rows_valid), 64'd0);
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        addr_q.delete(); row_q.delete();
        cur0 = '0; cur1 = '0; cur_valid = 1'b0;
        active = 0; pend_v = 0; just_committed = 0;
        read_en = 1'b1; addr = 5'd7;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; read_en = 1'b0;
        idle(2);
        step(1'b1, 5'd5, 1'b0);
        idle(12);

        // randomized traffic
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 4) == 0, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        idle(24);

        chk("addr queue drained", 64'(addr_q.size()), 64'd0);
        chk("row queue drained", 64'(row_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/row_fetch.md
Name: row_fetch

Overview:
- Upstream stage of the display controller.
- On a row request, reads the top-half row (addr) and the bottom-half row (addr+32) of one frame from the frame-buffer RAM, one word per cycle.
- Assembles each row into a 64-bit register and presents both rows atomically on row_0_out/row_1_out.
- Output rows are double-buffered: the panel shifter always sees a stable, complete row pair while the next pair is fetched.

Parameters:
- WORD_W, 16: RAM data width; must divide ROW_W.
- ROW_W, 64: bits per assembled row.
- WORDS, ROW_W/WORD_W (4): RAM words per row; derived, not overridable.
- ADDR_W, 1+1+5+log2(WORDS) (9): RAM address width; derived.

Ports:
- clk  in  1  system clock (HSOSC-derived).
- reset  in  1  asynchronous, active-high; clears all state.
- read_en  in  1  single-cycle row request from the display FSM.
- addr  in  5  panel row address (0..31) of the request.
- frame_sel  in  1  frame-buffer bank to read; sampled with the request.
- mem_ren  out  1  RAM read enable.
- mem_raddr  out  ADDR_W  RAM read address = {frame, half, row, word}.
- mem_rdata  in  WORD_W  RAM read data, valid exactly 1 cycle after mem_ren.
- row_0_out  out  ROW_W  committed top-half row (panel row addr).
- row_1_out  out  ROW_W  committed bottom-half row (panel row addr+32).
- rows_valid  out  1  high once at least one pair has been committed since reset.
- busy  out  1  high while a fetch is in progress.
- done  out  1  one-cycle pulse in the cycle after a commit.

Behaviour:
- Reset values: mem_ren=0, mem_raddr=0, row_0_out=0, row_1_out=0, rows_valid=0, busy=0, done=0; FSM=IDLE; pending request cleared; shadow registers=0.
- Request sampling: read_en=1 at rising edge E0 in IDLE latches addr and frame_sel into req regs, clears beat counter, and moves FSM to READ.
- READ state:
  - Issues 8 beats, one per cycle, in the cycles following E0..E7.
  - mem_ren=1 for each beat.
  - Beat b uses half=b[2], word=b[1:0], mem_raddr={frame, half, row_addr, word}.
  - Beats 0-3 read the top row, beats 4-7 the bottom row.
- Capture:
  - Data for beat b is captured into its shadow register at edge E(b+2).
  - Word w is written to bits [w*WORD_W +: WORD_W] (word 0 = LSBs).
  - Half 0 fills shadow_0, half 1 fills shadow_1.
- COMMIT state:
  - The FSM enters COMMIT after the last beat is issued (edge E8); mem_ren=0 from then on.
  - At E9 the last word is captured.
  - At E10: row_0_out<=shadow_0, row_1_out<=shadow_1 (both together), rows_valid<=1, done=1 for the following cycle.
- Latency: outputs update 10 edges after the request edge; a stalled pipeline is not supported (the RAM has a fixed 1-cycle latency).
- busy=1 from the cycle after E0 through the cycle ending at E10; busy=0 when returning to IDLE.
- Row outputs never change except at a commit edge; a partially fetched pair is never visible.
- Request while busy (any edge E1..E10):
  - Latched into a one-deep pending slot (addr, frame_sel).
  - A newer request overwrites an older pending one (latest wins).
- Pending request at E10: the FSM goes directly from COMMIT to READ using the pending request; that edge acts as E0 of the new fetch and the slot is cleared. done still pulses, and busy stays 1.
- A request arriving exactly at E10 takes priority over the pending slot and starts the next fetch.
- Back-to-back throughput: one row pair per 10 cycles.
- Request at IDLE simultaneous with reset: reset wins.
- Reset mid-fetch: immediately aborts. Outputs and shadows go to 0, rows_valid=0, and the pending request is dropped.
- addr wrap: bottom-row address is formed by the half bit; no arithmetic overflow is possible (addr 31 → panel rows 31 and 63).

Test Plan:
- Single fetch: RAM word at {f,h,r,w} = {7'h0,f,h,r,w} pattern; request addr=5, frame_sel=0 at E0.
  → mem_raddr sequence 0x014,0x015,0x016,0x017,0x094,0x095,0x096,0x097 with mem_ren high for 8 cycles; at E10 row_0_out/row_1_out equal those 4-word concatenations (word0 LSB); done pulses once; busy low afterwards.
- Boundary row: request addr=31, frame_sel=1.
  → addresses 0x17C..0x17F then 0x1FC..0x1FF; row_1_out holds panel row 63 data.
- Back-to-back: request addr=2 at E0, addr=9 at E3.
  → first commit at E10 (rows 2/34), second fetch starts at E10 and commits at E20 (rows 9/41); busy stays high throughout; done pulses at E10 and E20.
- Latest-wins: during one fetch, request addr=4 at E2 and addr=6 at E5.
  → only rows 6/38 are fetched next; addr 4 is never issued.
- Output stability: while the second fetch is in flight, row_0_out/row_1_out hold the first pair bit-exact until its commit edge.
- Reset mid-fetch: assert reset asynchronously at E4+half-cycle.
  → mem_ren=0, outputs=0, rows_valid=0 immediately; no commit or done; a new request after release behaves like the single-fetch case.
